// File: rtl/par_moody_source_pkg.sv
// Shared sizes, destination modes, FSM states and item layout for the moody source.
package par_moody_source_pkg;

    localparam int unsigned HDR_SZ  = 8;
    localparam int unsigned PL_SZ   = 8;
    localparam int unsigned ADDR_SZ = 4;
    localparam int unsigned ITEM_SZ = HDR_SZ + PL_SZ + ADDR_SZ;
    localparam int unsigned LFSR_SZ = 16;

    localparam logic [1:0] DEST_FIXED      = 2'd0;
    localparam logic [1:0] DEST_RANDOM     = 2'd1;
    localparam logic [1:0] DEST_COMPLEMENT = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic [HDR_SZ-1:0]  src;
        logic [PL_SZ-1:0]   payload;
        logic [ADDR_SZ-1:0] addr;
    } item_t;

    // Random destinations never target the source itself.
    function automatic logic [ADDR_SZ-1:0] pick_dest(
        input logic [1:0]         mode,
        input logic [ADDR_SZ-1:0] self_id,
        input logic [ADDR_SZ-1:0] fixed_dest,
        input logic [7:0]         rnd
    );
        logic [ADDR_SZ-1:0] d;
        d = fixed_dest;
        case (mode)
            DEST_RANDOM: begin
                d = ADDR_SZ'(rnd);
                if (d == self_id) d = self_id ^ ADDR_SZ'(1);
            end
            DEST_COMPLEMENT: d = ~self_id;
            default: d = fixed_dest;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/par_moody_source_if.sv
// Item channel between a moody source (master) and its receiver (slave).
interface par_moody_source_if import par_moody_source_pkg::*;;

    logic  enable;
    logic  channel_busy;
    item_t item_out;
    logic  valid;
    logic  done;

    modport master (
        input  enable,
        input  channel_busy,
        output item_out,
        output valid,
        output done
    );

    modport slave (
        output enable,
        output channel_busy,
        input  item_out,
        input  valid,
        input  done
    );

endinterface

// File: rtl/par_moody_source_lfsr16.sv
// moody_lfsr16: free-running 16-bit Galois LFSR, x^16+x^14+x^13+x^11+1; a zero seed is forced to 1.
module moody_lfsr16 #(
    parameter logic [15:0] seed = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset,
    output logic [15:0] state
);

    localparam logic [15:0] TAPS     = 16'hB400;
    localparam logic [15:0] SEED_EFF = (seed == 16'h0000) ? 16'h0001 : seed;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= SEED_EFF;
        else       state <= {1'b0, state[15:1]} ^ (state[0] ? TAPS : 16'h0000);
    end

endmodule

// File: rtl/par_moody_source.sv
// Pseudo-random packet injector holding each item stable under backpressure.
// Optional MOODY_SOURCE_TRACE_EN adds simulation-only transfer trace and held-item checker.
module par_moody_source
    import par_moody_source_pkg::*;
#(
    parameter int unsigned id          = 0,
    parameter int unsigned rate        = 128,
    parameter int unsigned dest_mode   = 0,
    parameter int unsigned fixed_dest  = 0,
    parameter int unsigned max_packets = 0,
    parameter logic [15:0] seed        = 16'hACE1
) (
    input  logic               clk,
    input  logic               reset,
    par_moody_source_if.master ch
);

    localparam logic [1:0]         MODE    = 2'(dest_mode);
    localparam logic [15:0]        QUOTA   = 16'(max_packets);
    localparam logic [HDR_SZ-1:0]  SRC_ID  = HDR_SZ'(id);
    localparam logic [ADDR_SZ-1:0] SELF_A  = ADDR_SZ'(id);
    localparam logic [ADDR_SZ-1:0] FIXED_A = ADDR_SZ'(fixed_dest);
    localparam logic [8:0]         RATE9   = 9'(rate);

    logic [LFSR_SZ-1:0] lfsr;
    state_t             state_q, state_d;
    item_t              item_q, item_d;
    logic [PL_SZ-1:0]   seq_q, seq_d;
    logic [15:0]        sent_q, sent_d;
    logic               valid_q, valid_d;
    logic               done_q, done_d;
    logic               inject_c;
    logic [ADDR_SZ-1:0] dest_c;

    moody_lfsr16 #(.seed(seed)) u_lfsr (
        .clk   (clk),
        .reset (reset),
        .state (lfsr)
    );

    assign inject_c = ch.enable && ({1'b0, lfsr[7:0]} < RATE9);
    assign dest_c   = pick_dest(MODE, SELF_A, FIXED_A, lfsr[15:8]);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            item_q  <= '0;
            seq_q   <= '0;
            sent_q  <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            item_q  <= item_d;
            seq_q   <= seq_d;
            sent_q  <= sent_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    // Next item always carries the post-transfer sequence number.
    always_comb begin
        state_d = state_q;
        item_d  = item_q;
        seq_d   = seq_q;
        sent_d  = sent_q;
        case (state_q)
            ST_IDLE: begin
                if (inject_c) begin
                    state_d = ST_SEND;
                    item_d  = '{src: SRC_ID, payload: seq_q, addr: dest_c};
                end
            end
            ST_SEND: begin
                if (!ch.channel_busy) begin
                    seq_d  = seq_q + PL_SZ'(1);
                    sent_d = (sent_q == 16'hFFFF) ? sent_q : sent_q + 16'd1;
                    if (QUOTA != 16'd0 && sent_d == QUOTA) begin
                        state_d = ST_DONE;
                    end else if (inject_c) begin
                        item_d = '{src: SRC_ID, payload: seq_d, addr: dest_c};
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_DONE: state_d = ST_DONE;
            default: state_d = ST_IDLE;
        endcase
        valid_d = (state_d == ST_SEND);
        done_d  = (state_d == ST_DONE);
    end

    assign ch.item_out = item_q;
    assign ch.valid    = valid_q;
    assign ch.done     = done_q;

`ifdef MOODY_SOURCE_TRACE_EN
    logic  held_q;
    item_t held_item_q;

    always_ff @(posedge clk) begin
        if (!reset && ch.valid && !ch.channel_busy)
            $display("##,tx,%0d,%0d,%0d", id, ch.item_out.payload, ch.item_out.addr);
        if (!reset && held_q && ch.item_out != held_item_q)
            $display("*****tx violation in %0d @ %0t", id, $time);
        held_q      <= !reset && ch.valid && ch.channel_busy;
        held_item_q <= ch.item_out;
    end
`else
    // Trace and held-item checker compiled out.
`endif

endmodule

// File: doc/par_moody_source.md
# par_moody_source

Packet injector for the parallel NoC test library and the transmit-side counterpart of the moody sink. It drives one channel into a router or sink with `{header, payload, address}` items. It decides each injection pseudo-randomly at a programmable rate and holds every item stable under backpressure until the receiver accepts it. It stamps the source id, a sequence number and the destination into each item so that sinks can check delivery.

## Interface
- `id`, default 0: source node id; goes into the header field, zero-extended to `HDR_SZ`.
- `rate`, default 128: injection probability ×256, range 0–256; 0 never injects, 256 always injects.
- `dest_mode`, default 0: 0 fixed destination; 1 uniform random; 2 bit-complement of `id`.
- `fixed_dest`, default 0: destination used when `dest_mode` = 0.
- `max_packets`, default 0: packet quota; 0 means unlimited.
- `seed`, default 16'hACE1: LFSR seed; a value of 0 is replaced by 1.
- `clk` input 1: clock, rising edge.
- `reset` input 1: asynchronous, active-high.
- `enable` input 1: permits new injections.
- `channel_busy` input 1: receiver backpressure.
- `item_out` output `HDR_SZ+PL_SZ+ADDR_SZ`: `{src id, payload = seq, dest addr}`, MSB to LSB.
- `valid` output 1: `item_out` is offered.
- `done` output 1: quota reached.

## Operation
- States:
  - IDLE: no item offered.
  - SEND: `valid`=1, item held.
  - DONE: quota exhausted, terminal until reset.
- LFSR: 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1. It advances every cycle when not in reset.
- Injection decision: `inject = enable && ({1'b0, lfsr[7:0]} < rate)`, a 9-bit compare.
- Destination, width `ADDR_SZ` (`ADDR_SZ` ≤ 8):
  - Mode 0: `fixed_dest`.
  - Mode 1: `lfsr[15:8]` truncated; if the result equals `id`, use `id ^ 1`.
  - Mode 2: `~id`.
- Transfer occurs on a rising edge where `valid && !channel_busy`.
- IDLE → SEND on `inject`. The item is registered on the same edge.
- SEND stays in SEND while `channel_busy`. `item_out` and `valid` must not change while held.
- On transfer:
  - `seq` and `sent` are incremented.
  - If the new `sent` equals `max_packets` (nonzero): → DONE.
  - Else if `inject` in the same cycle: stay in SEND with the next item (back-to-back).
  - Else: → IDLE.
- `enable` low blocks only new injections. An item already offered stays offered until accepted.
- `seq` is `PL_SZ` bits and wraps from all-ones to 0. `sent` is 16 bits and saturates.
- DONE: `valid`=0, `done`=1. Ignores `enable` and `channel_busy`.

## Timing
- Reset values:
  - `valid`=0, `item_out`=0, `done`=0
  - `seq`=0, `sent`=0, state IDLE
  - `lfsr`=`seed` (1 if `seed` = 0)
- Latency: `valid` rises 1 cycle after the edge at which `inject` is true.
- Throughput: one item per cycle at `rate`=256 with `channel_busy` low.
- `channel_busy` is sampled at the edge only. There is no combinational path from `channel_busy` to any output.
- Reset asserted mid-SEND drops `valid` immediately (asynchronously). The pending item is lost and `seq` restarts at 0.
- If the quota is hit on a back-to-back transfer, DONE wins and no further item is offered.

## Configuration
- `MOODY_SOURCE_TRACE_EN` defined:
  - Each transfer prints `##,tx,<id>,<seq>,<dest>`.
  - An attempt to change a held item prints `*****tx violation in <id> @ <time>`, which is simulation-only.
- Undefined: no display statements and no checker logic. Functional behaviour is identical.

## Structure
- Shared defines header: `HDR_SZ`, `PL_SZ`, `ADDR_SZ` (already global), plus `DEST_FIXED`=0, `DEST_RANDOM`=1, `DEST_COMPLEMENT`=2 and the state encodings.
- One sub-module, `moody_lfsr16`: parameter `seed`; ports `clk`, `reset`, `state[15:0]`. It is reusable by other traffic generators.
- Top-level `par_moody_source` wraps the FSM, counters and item register.

## Test plan
All scenarios run on a bench with `HDR_SZ`=8, `PL_SZ`=8, `ADDR_SZ`=4, `id`=3.

1. `rate`=256, `dest_mode`=0, `fixed_dest`=5, `channel_busy`=0 → `valid` rises 1 cycle after reset release; items are 0x03_00_5, 0x03_01_5, 0x03_02_5 on consecutive cycles.
2. `channel_busy` held high for 10 cycles while `valid`=1 → `item_out` is constant for all 10 cycles; transfer happens on the first edge with busy low; `seq` increments by exactly 1.
3. `max_packets`=4, `rate`=256 → exactly 4 transfers, then `valid`=0 and `done`=1 permanently; `sent`=4.
4. `rate`=0 → `valid` stays 0 for 1000 cycles. Separately, `rate`=128 over 10000 cycles with busy=0 → injection count within 5000±300.
5. `dest_mode`=1 over 2000 packets → destination 3 never appears; every destination 0–15 other than 3 appears. `dest_mode`=2 → destination 0xC.
6. `enable` deasserted while `valid`=1 and busy high, then busy released → the held item still transfers, and no new `valid` appears. Reset asserted mid-SEND → `valid`=0 immediately; after release the first item has `seq`=0.
